// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encodings and word geometry.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects bytes LSB-first into a 32-bit word. The finished word is
// latched into its own output register together with a one-cycle word_valid, so
// the next word can start packing on the very next byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic [BCNT_W-1:0] cnt,
  output logic              word_valid,
  output logic [31:0]       word
);

  logic [23:0] acc;

  // byte counter, partial-word accumulator and finished-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      cnt        <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        case (cnt)
          2'd0:    acc[7:0]   <= in_data;
          2'd1:    acc[15:8]  <= in_data;
          2'd2:    acc[23:16] <= in_data;
          default: begin
            word       <= {in_data, acc};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (N_lo, N_hi, 4*N data bytes
// [, XOR checksum]) and writes the packed little-endian words to the
// instruction memory at byte addresses 0, 4, 8, ...
// Optional feature macro: CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W:0]       DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [BCNT_W-1:0]    LAST_B  = BCNT_W'(WORD_BYTES-1);
`ifdef CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state, state_nxt;
  logic              go, xfer, last_byte, last_word;
  logic [7:0]        cnt_lo;
  logic [CNT_W-1:0]  hdr, n_words, idx;
  logic              in_range_q, err_q;
  logic [31:0]       wa_q;
  logic [BCNT_W-1:0] bcnt;
  logic              word_valid;
  logic [31:0]       word;

  assign rx_ready  = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA) || (state == S_CHK);
  assign busy      = rx_ready;
  assign done      = (state == S_DONE);
  assign go        = start && ((state == S_IDLE) || (state == S_DONE));
  assign xfer      = rx_valid && rx_ready;
  assign hdr       = CNT_W'({rx_data, cnt_lo});
  assign last_byte = xfer && (state == S_DATA) && (bcnt == LAST_B);
  assign last_word = (idx == n_words - 1'b1);

  word_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (go),
    .in_valid   (xfer && (state == S_DATA)),
    .in_data    (rx_data),
    .cnt        (bcnt),
    .word_valid (word_valid),
    .word       (word)
  );

  // out-of-range words are packed but their write pulse is masked
  assign we = word_valid && in_range_q;
  assign wa = wa_q;
  assign wd = word;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic: frame sequencing driven by accepted bytes
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_HDR0;
      S_HDR0:         if (xfer) state_nxt = S_HDR1;
      S_HDR1:         if (xfer) state_nxt = (hdr == '0) ? S_END : S_DATA;
      S_DATA:         if (last_byte && last_word) state_nxt = S_END;
`ifdef CHECKSUM_EN
      S_CHK:          if (xfer) state_nxt = S_DONE;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  // header capture, word index, write address and range/overflow flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo     <= '0;
      n_words    <= '0;
      idx        <= '0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
      wa_q       <= '0;
    end else if (go) begin
      n_words    <= '0;
      idx        <= '0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (xfer) begin
      case (state)
        S_HDR0: cnt_lo <= rx_data;
        S_HDR1: begin
          n_words <= hdr;
          if ({1'b0, hdr} > DEPTH_C) err_q <= 1'b1;
        end
        S_DATA: if (bcnt == LAST_B) begin
          in_range_q <= ({1'b0, idx} < DEPTH_C);
          wa_q       <= 32'({idx, 2'b00});
          idx        <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] xsum;
  logic       chk_err;

  // running XOR over header and data bytes, compared with the trailing byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsum    <= '0;
      chk_err <= 1'b0;
    end else if (go) begin
      xsum    <= '0;
      chk_err <= 1'b0;
    end else if (xfer) begin
      if (state == S_CHK) chk_err <= (rx_data != xsum);
      else                xsum    <= xsum ^ rx_data;
    end
  end

  assign err = err_q | chk_err;
`else
  assign err = err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// with random inter-byte gaps, checked against a frame-level reference model.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int CNT_W = 16;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, we, busy, done, err;
  logic [31:0] wa, wd;

  int n_tests = 0, n_fail = 0;
  logic [31:0] obs_a[$], obs_d[$];
  bit watch = 1'b0, busy_low = 1'b0;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // write-port monitor and busy watchdog, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      obs_a.push_back(wa);
      obs_d.push_back(wd);
    end
    if (watch && !busy) busy_low = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Builds a frame, streams it, and checks writes/done/err against the model:
  // word i (i < min(N,DEPTH)) lands at 4*i with its four bytes little-endian.
  task automatic run_frame(input string name, input int n, input int gap_max,
                           input bit fixed1, input bit bad_chk, input bit poke);
    logic [7:0]  s[$];
    logic [31:0] w, ed;
    logic [7:0]  x;
    int          nexp, gap;
    bit          eerr;
    obs_a.delete();
    obs_d.delete();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      if (fixed1) w = (i == 0) ? 32'h00A00293 : 32'h00000013;
      else        w = $urandom;
      for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
    end
    eerr = (n > DEPTH);
`ifdef CHECKSUM_EN
    x = '0;
    foreach (s[k]) x ^= s[k];
    s.push_back(bad_chk ? (x ^ 8'h01) : x);
    eerr = eerr || bad_chk;
`else
    x = '0;
    if (bad_chk) eerr = eerr || (x != 8'h00);
`endif
    pulse_start();
    busy_low = 1'b0;
    watch    = 1'b1;
    foreach (s[k]) begin
      if (k == s.size() - 1) watch = 1'b0;
      send(s[k]);
      if (poke && k == 2) begin
        pulse_start();
        chk({name, "_busy_after_poke"}, {31'd0, busy}, 32'd1);
      end
      if (k != s.size() - 1) begin
        gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (gap) @(negedge clk);
      end
    end
    watch = 1'b0;
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    nexp = (n < DEPTH) ? n : DEPTH;
    chk({name, "_nwrites"}, obs_a.size(), nexp);
    for (int i = 0; i < nexp && i < obs_a.size(); i++) begin
      ed = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      chk($sformatf("%s_wa%0d", name, i), obs_a[i], 32'(i * 4));
      chk($sformatf("%s_wd%0d", name, i), obs_d[i], ed);
    end
    chk({name, "_err"}, {31'd0, err}, {31'd0, eerr});
    chk({name, "_busy_hold"}, {31'd0, busy_low}, 32'd0);
    chk({name, "_done_hold"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_we",       {31'd0, we},       32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_wa",       wa,                32'd0);
    chk("rst_wd",       wd,                32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // two-word program, no gaps / with 3-cycle gaps
    run_frame("f1", 2, 0, 1'b1, 1'b0, 1'b0);
    begin
      obs_a.delete();
      pulse_start();
      watch = 1'b1; busy_low = 1'b0;
      watch = 1'b0;
    end
    run_frame("f1gap", 2, 3, 1'b1, 1'b0, 1'b0);

    // oversize frame: N = DEPTH+1
    run_frame("ovf", DEPTH + 1, 0, 1'b0, 1'b0, 1'b0);
    chk("ovf_last_wa", obs_a.size() > 0 ? obs_a[obs_a.size()-1] : 32'hFFFF_FFFF, 32'h0000_00FC);

    // reset in the middle of a frame discards the partial word
    obs_a.delete();
    obs_d.delete();
    pulse_start();
    send(8'h02); send(8'h00); send(8'h93); send(8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy",  {31'd0, busy},  32'd0);
    chk("midrst_ready", {31'd0, rx_ready}, 32'd0);
    chk("midrst_done",  {31'd0, done},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_nowrite", obs_a.size(), 0);
    run_frame("f1post", 2, 1, 1'b1, 1'b0, 1'b0);

    // empty frame, and start pulsed while busy
    run_frame("empty", 0, 0, 1'b0, 1'b0, 1'b0);
    run_frame("poke", 3, 2, 1'b0, 1'b0, 1'b1);

`ifdef CHECKSUM_EN
    run_frame("f1chk_ok",  2, 0, 1'b1, 1'b0, 1'b0);
    run_frame("f1chk_bad", 2, 0, 1'b1, 1'b1, 1'b0);
`endif

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      run_frame($sformatf("rnd%0d", r), $urandom_range(0, DEPTH + 6),
                $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
